kernel7_window_ctrl: RTL and testbench

Frame-level sequencer for the 7x7 sliding-window line buffer. Accepts a raster-order pixel stream with a valid/ready handshake and drives the line buffer's shift enable and data input. It tracks the row/column of every accepted pixel and flags exactly those cycles where the buffer holds a complete in-image 7x7 window, reporting the window centre. Downstream backpressure freezes the buffer, so a flagged window stays stable until it is consumed.

---
 rtl/kernel7_window_ctrl.sv | 129 ++++++++++++
 tb/tb_kernel7_window_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel7_window_ctrl.sv
// Frame sequencer for a 7x7 sliding-window line buffer: paces raster pixels into
// the buffer and flags cycles where the taps hold a complete in-image window.
module kernel7_window_ctrl #(
  parameter int IMG_Width  = 8,
  parameter int IMG_Height = 8,
  parameter int Datawidth  = 8,
  parameter int CW = (IMG_Width  > 2) ? $clog2(IMG_Width)  : 1,
  parameter int RW = (IMG_Height > 2) ? $clog2(IMG_Height) : 1
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic                 Start,
  input  logic [Datawidth-1:0] Pix_In,
  input  logic                 Pix_Valid,
  output logic                 Pix_Ready,
  output logic [Datawidth-1:0] LB_Data,
  output logic                 LB_Shift,
  output logic                 Win_Valid,
  input  logic                 Win_Ready,
  output logic [RW-1:0]        Win_Row,
  output logic [CW-1:0]        Win_Col,
  output logic                 Busy,
  output logic                 Frame_Done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_Width - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_Height - 1);
  localparam logic [CW-1:0] COL_QUAL = CW'(6);
  localparam logic [RW-1:0] ROW_QUAL = RW'(6);

  state_t        state_reg, state_next;
  logic [CW-1:0] col_reg, col_next;
  logic [RW-1:0] row_reg, row_next;
  logic          win_valid_reg, win_valid_next;
  logic [RW-1:0] win_row_reg, win_row_next;
  logic [CW-1:0] win_col_reg, win_col_next;

  logic accept;
  logic qualify;
  logic last_col;
  logic last_pix;

  // A pending window blocks new pixels unless it is being consumed this cycle,
  // which keeps the taps frozen under backpressure.
  assign Pix_Ready  = (state_reg == RUN) & (~win_valid_reg | Win_Ready);
  assign accept     = Pix_Valid & Pix_Ready;
  assign LB_Data    = Pix_In;
  assign LB_Shift   = accept;
  assign Win_Valid  = win_valid_reg;
  assign Win_Row    = win_row_reg;
  assign Win_Col    = win_col_reg;
  assign Busy       = (state_reg == RUN) | (state_reg == DRAIN);
  assign Frame_Done = (state_reg == DONE);

  assign last_col = (col_reg == COL_LAST);
  assign last_pix = last_col & (row_reg == ROW_LAST);
  assign qualify  = (row_reg >= ROW_QUAL) & (col_reg >= COL_QUAL);

  always_comb begin
    state_next     = state_reg;
    col_next       = col_reg;
    row_next       = row_reg;
    win_valid_next = win_valid_reg;
    win_row_next   = win_row_reg;
    win_col_next   = win_col_reg;

    if (accept) begin
      if (last_col) begin
        col_next = '0;
        row_next = row_reg + RW'(1);
      end else begin
        col_next = col_reg + CW'(1);
      end
      win_valid_next = qualify;
      if (qualify) begin
        win_row_next = row_reg - RW'(3);
        win_col_next = col_reg - CW'(3);
      end
    end else if (Win_Ready) begin
      win_valid_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (Start) begin
          state_next     = RUN;
          col_next       = '0;
          row_next       = '0;
          win_valid_next = 1'b0;
          win_row_next   = '0;
          win_col_next   = '0;
        end
      end
      RUN: begin
        if (accept && last_pix) state_next = DRAIN;
      end
      DRAIN: begin
        if (win_valid_reg && Win_Ready) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state_reg     <= IDLE;
      col_reg       <= '0;
      row_reg       <= '0;
      win_valid_reg <= 1'b0;
      win_row_reg   <= '0;
      win_col_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      col_reg       <= col_next;
      row_reg       <= row_next;
      win_valid_reg <= win_valid_next;
      win_row_reg   <= win_row_next;
      win_col_reg   <= win_col_next;
    end
  end

endmodule

// File: tb/tb_kernel7_window_ctrl.sv
// Self-checking bench for kernel7_window_ctrl: 8x8 and 10x9 instances, a tap-chain
// model of the line buffer and a scoreboard of expected window centres.
`timescale 1ns/1ps
module tb_kernel7_window_ctrl;

  localparam int HALF = 5;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic       Start = 1'b0;
  logic       Pix_Valid = 1'b0;
  logic       Win_Ready = 1'b1;
  logic [7:0] Pix_In = 8'd0;

  always #HALF CLK = ~CLK;

  logic       a_ready, a_shift, a_wv, a_busy, a_done;
  logic [7:0] a_lbdata;
  logic [2:0] a_row, a_col;
  logic       b_ready, b_shift, b_wv, b_busy, b_done;
  logic [7:0] b_lbdata;
  logic [3:0] b_row, b_col;

  kernel7_window_ctrl #(.IMG_Width(8), .IMG_Height(8), .Datawidth(8)) dut_a (
    .CLK(CLK), .CLR(CLR), .Start(Start), .Pix_In(Pix_In), .Pix_Valid(Pix_Valid),
    .Pix_Ready(a_ready), .LB_Data(a_lbdata), .LB_Shift(a_shift), .Win_Valid(a_wv),
    .Win_Ready(Win_Ready), .Win_Row(a_row), .Win_Col(a_col), .Busy(a_busy),
    .Frame_Done(a_done)
  );

  kernel7_window_ctrl #(.IMG_Width(10), .IMG_Height(9), .Datawidth(8)) dut_b (
    .CLK(CLK), .CLR(CLR), .Start(Start), .Pix_In(Pix_In), .Pix_Valid(Pix_Valid),
    .Pix_Ready(b_ready), .LB_Data(b_lbdata), .LB_Shift(b_shift), .Win_Valid(b_wv),
    .Win_Ready(Win_Ready), .Win_Row(b_row), .Win_Col(b_col), .Busy(b_busy),
    .Frame_Done(b_done)
  );

  logic       sel = 1'b0;
  logic       cur_ready, cur_shift, cur_wv, cur_busy, cur_done;
  logic [7:0] cur_lbdata;
  logic [3:0] cur_row, cur_col;

  assign cur_ready  = sel ? b_ready  : a_ready;
  assign cur_shift  = sel ? b_shift  : a_shift;
  assign cur_wv     = sel ? b_wv     : a_wv;
  assign cur_busy   = sel ? b_busy   : a_busy;
  assign cur_done   = sel ? b_done   : a_done;
  assign cur_lbdata = sel ? b_lbdata : a_lbdata;
  assign cur_row    = sel ? b_row    : {1'b0, a_row};
  assign cur_col    = sel ? b_col    : {1'b0, a_col};

  // Line-buffer model: taps[0] is the newest pixel, taps[6W+6] the window's top-left.
  logic [7:0] taps [0:66];
  always @(posedge CLK) begin
    if (cur_shift) begin
      taps[0] <= cur_lbdata;
      for (int i = 1; i < 67; i++) taps[i] <= taps[i-1];
    end
  end

  int checks = 0;
  int errors = 0;
  int W = 8;
  int H = 8;
  int m_row, m_col, m_acc;
  int exp_q[$];
  int win_cnt, shift_cnt, done_cnt, done_cyc;

  task automatic apply_reset();
    @(negedge CLK);
    CLR = 1'b0;
    Pix_Valid = 1'b0;
    Start = 1'b0;
    Win_Ready = 1'b1;
    repeat (2) @(negedge CLK);
    CLR = 1'b1;
    exp_q.delete();
  endtask

  // Leaves the caller at the negedge right after the edge that samples Start.
  task automatic start_frame();
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
  endtask

  task automatic drive_frame(input int gap_pct, input int stop_after);
    int n_cyc;
    m_row = 0; m_col = 0; m_acc = 0; n_cyc = 0;
    while (m_acc < W*H && m_acc != stop_after && n_cyc < 2000) begin
      Pix_Valid = ($urandom_range(99) >= gap_pct);
      Pix_In = 8'(W*m_row + m_col);
      #1;
      if (Pix_Valid && cur_ready) begin
        checks++;
        if (cur_lbdata !== Pix_In) begin
          errors++;
          $display("FAIL lb_data got %0d expected %0d", cur_lbdata, Pix_In);
        end
        if (m_row >= 6 && m_col >= 6) exp_q.push_back((m_row-3)*256 + (m_col-3));
        m_acc++;
        if (m_col == W-1) begin m_col = 0; m_row++; end
        else m_col++;
      end
      @(posedge CLK);
      @(negedge CLK);
      n_cyc++;
    end
    Pix_Valid = 1'b0;
    if (n_cyc >= 2000) begin
      errors++;
      $display("FAIL drive_timeout accepted %0d expected %0d", m_acc, W*H);
    end
  endtask

  task automatic watch_frame(input int max_cyc, input bit expect_done);
    bit seen;
    int e, er, ec;
    win_cnt = 0; shift_cnt = 0; done_cnt = 0; done_cyc = 0; seen = 0;
    for (int cyc = 1; cyc <= max_cyc && !seen; cyc++) begin
      #2;
      if (cur_shift) shift_cnt++;
      if (cur_wv && Win_Ready) begin
        win_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_window got (%0d,%0d) expected none", cur_row, cur_col);
        end else begin
          e = exp_q.pop_front();
          er = e / 256;
          ec = e % 256;
          if (cur_row !== 4'(er) || cur_col !== 4'(ec)) begin
            errors++;
            $display("FAIL win_pos got (%0d,%0d) expected (%0d,%0d)", cur_row, cur_col, er, ec);
          end
          checks++;
          if (taps[3*W+3] !== 8'(W*er + ec)) begin
            errors++;
            $display("FAIL tap_centre got %0d expected %0d", taps[3*W+3], W*er + ec);
          end
          checks++;
          if (taps[6*W+6] !== 8'(W*(er-3) + ec-3)) begin
            errors++;
            $display("FAIL tap_corner got %0d expected %0d", taps[6*W+6], W*(er-3) + ec-3);
          end
          checks++;
          if (cur_col > 4'(W-4)) begin
            errors++;
            $display("FAIL win_col_range got %0d expected <= %0d", cur_col, W-4);
          end
        end
      end
      if (cur_done) begin
        seen = 1;
        done_cnt++;
        done_cyc = cyc;
        checks++;
        if (cur_busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_in_done got %0b expected 0", cur_busy);
        end
      end
      @(negedge CLK);
    end
    if (expect_done) begin
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL done_timeout got no Frame_Done expected one within %0d cycles", max_cyc);
      end
    end
  endtask

  task automatic check_totals(input string tag, input int wins, input int shifts);
    checks++;
    if (win_cnt != wins) begin
      errors++;
      $display("FAIL %s win_count got %0d expected %0d", tag, win_cnt, wins);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_windows got %0d left expected 0", tag, exp_q.size());
    end
    checks++;
    if (shift_cnt != shifts) begin
      errors++;
      $display("FAIL %s shift_count got %0d expected %0d", tag, shift_cnt, shifts);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s done_count got %0d expected 1", tag, done_cnt);
    end
    $display("%s: windows %0d shifts %0d done %0d", tag, win_cnt, shift_cnt, done_cnt);
  endtask

  task automatic test_reset();
    CLR = 1'b0; Pix_Valid = 1'b1; Start = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({a_ready, a_shift, a_wv, a_busy, a_done} !== 5'b0 || a_row !== 3'd0 || a_col !== 3'd0) begin
      errors++;
      $display("FAIL reset_a got rdy%0b sh%0b wv%0b busy%0b done%0b row%0d col%0d expected all 0",
               a_ready, a_shift, a_wv, a_busy, a_done, a_row, a_col);
    end
    checks++;
    if ({b_ready, b_shift, b_wv, b_busy, b_done} !== 5'b0 || b_row !== 4'd0 || b_col !== 4'd0) begin
      errors++;
      $display("FAIL reset_b got rdy%0b sh%0b wv%0b busy%0b done%0b expected all 0",
               b_ready, b_shift, b_wv, b_busy, b_done);
    end
    Pix_Valid = 1'b0;
    CLR = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_full_rate();
    sel = 1'b0; W = 8; H = 8;
    apply_reset();
    start_frame();
    fork
      drive_frame(0, -1);
      watch_frame(300, 1);
    join
    check_totals("full_rate", 4, 64);
    checks++;
    if (done_cyc != 66) begin
      errors++;
      $display("FAIL done_latency got %0d expected 66", done_cyc);
    end
  endtask

  task automatic test_backpressure();
    sel = 1'b0; W = 8; H = 8;
    apply_reset();
    start_frame();
    fork
      drive_frame(0, -1);
      watch_frame(300, 1);
      begin : stall
        int k;
        k = 0;
        while (!cur_wv && k < 300) begin @(negedge CLK); k++; end
        Win_Ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          #1;
          checks++;
          if (cur_ready !== 1'b0 || cur_shift !== 1'b0 || cur_wv !== 1'b1) begin
            errors++;
            $display("FAIL stall_handshake cycle %0d got rdy%0b sh%0b wv%0b expected 0 0 1",
                     s, cur_ready, cur_shift, cur_wv);
          end
          checks++;
          if (cur_row !== 4'd3 || cur_col !== 4'd3 || taps[27] !== 8'd27) begin
            errors++;
            $display("FAIL stall_hold cycle %0d got (%0d,%0d) tap %0d expected (3,3) tap 27",
                     s, cur_row, cur_col, taps[27]);
          end
          @(negedge CLK);
        end
        Win_Ready = 1'b1;
      end
    join
    check_totals("backpressure", 4, 64);
  endtask

  task automatic test_random_gaps();
    sel = 1'b0; W = 8; H = 8;
    apply_reset();
    start_frame();
    fork
      drive_frame(50, -1);
      watch_frame(1500, 1);
    join
    check_totals("random_gaps", 4, 64);
  endtask

  task automatic test_wide_frame();
    sel = 1'b1; W = 10; H = 9;
    apply_reset();
    start_frame();
    fork
      drive_frame(0, -1);
      watch_frame(400, 1);
    join
    check_totals("wide_frame", 12, 90);
    sel = 1'b0; W = 8; H = 8;
  endtask

  task automatic test_reset_mid_frame();
    sel = 1'b0; W = 8; H = 8;
    apply_reset();
    start_frame();
    drive_frame(0, 30);
    CLR = 1'b0;
    @(negedge CLK);
    CLR = 1'b1;
    #1;
    checks++;
    if (cur_busy !== 1'b0 || cur_ready !== 1'b0 || cur_wv !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got busy%0b rdy%0b wv%0b expected 0 0 0", cur_busy, cur_ready, cur_wv);
    end
    @(negedge CLK);
    exp_q.delete();
    start_frame();
    fork
      drive_frame(0, -1);
      watch_frame(300, 1);
    join
    check_totals("reset_mid_frame", 4, 64);
  endtask

  task automatic test_start_ignored();
    sel = 1'b0; W = 8; H = 8;
    apply_reset();
    start_frame();
    fork
      drive_frame(0, -1);
      watch_frame(300, 1);
      begin : pulses
        int k;
        repeat (20) @(negedge CLK);
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        k = 0;
        while (!(cur_wv && m_acc == W*H) && k < 300) begin @(negedge CLK); k++; end
        Win_Ready = 1'b0;
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        #1;
        checks++;
        if (cur_busy !== 1'b1 || cur_wv !== 1'b1) begin
          errors++;
          $display("FAIL drain_hold got busy%0b wv%0b expected 1 1", cur_busy, cur_wv);
        end
        Win_Ready = 1'b1;
      end
    join
    check_totals("start_ignored", 4, 64);
    watch_frame(10, 0);
    checks++;
    if (done_cnt != 0 || cur_busy !== 1'b0) begin
      errors++;
      $display("FAIL no_restart got done%0d busy%0b expected 0 0", done_cnt, cur_busy);
    end
    CLR = 1'b0;
    Start = 1'b1;
    @(negedge CLK);
    CLR = 1'b1;
    Start = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (cur_busy !== 1'b0 || cur_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_with_clr got busy%0b rdy%0b expected 0 0", cur_busy, cur_ready);
    end
    $display("start_with_clr: busy %0b ready %0b", cur_busy, cur_ready);
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_backpressure();
    test_random_gaps();
    test_wide_frame();
    test_reset_mid_frame();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
